// File: rtl/ka_seq_mul_ctrl.sv
// Carry-less Karatsuba multiplier controller: one N-bit GF(2) product via a shared external HxH multiplier.
// Four busy cycles per operation (LO, HI, MID, DONE); results are held in DONE until the sink accepts them.
module ka_seq_mul_ctrl #(
    parameter int N = 10,
    parameter int H = N / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    output logic [H-1:0]     mul_op_a,
    output logic [H-1:0]     mul_op_b,
    input  logic [2*H-2:0]   mul_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-2:0]   c_out,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, DONE} state_t;

    state_t           state;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [2*H-2:0]   p0;
    logic [2*H-2:0]   p2;
    logic [2*H-2:0]   mid;
    logic [2*N-2:0]   p0_x;
    logic [2*N-2:0]   mid_x;
    logic [2*N-2:0]   p2_x;
    logic [2*N-2:0]   prod;

    // The multiplier sees the cross-term operands while in MUL_MID, so mul_res is (Alo^Ahi)(Blo^Bhi).
    always_comb begin
        mid   = mul_res ^ p0 ^ p2;
        p0_x  = (2*N-1)'(p0);
        mid_x = (2*N-1)'(mid);
        p2_x  = (2*N-1)'(p2);
        prod  = p0_x ^ (mid_x << H) ^ (p2_x << (2*H));
    end

    // Operands are registered one state ahead so they are stable for the whole state that consumes mul_res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            c_out     <= '0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p0        <= '0;
            p2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        mul_op_a <= a_in[H-1:0];
                        mul_op_b <= b_in[H-1:0];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL_LO;
                    end
                end
                MUL_LO: begin
                    p0       <= mul_res;
                    mul_op_a <= a_reg[N-1:H];
                    mul_op_b <= b_reg[N-1:H];
                    state    <= MUL_HI;
                end
                MUL_HI: begin
                    p2       <= mul_res;
                    mul_op_a <= a_reg[H-1:0] ^ a_reg[N-1:H];
                    mul_op_b <= b_reg[H-1:0] ^ b_reg[N-1:H];
                    state    <= MUL_MID;
                end
                MUL_MID: begin
                    c_out     <= prod;
                    mul_op_a  <= '0;
                    mul_op_b  <= '0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    mul_op_a  <= '0;
                    mul_op_b  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ka_seq_mul_ctrl.sv
// Directed and randomized checks of ka_seq_mul_ctrl against a plain shift-and-XOR reference multiply.
module tb_ka_seq_mul_ctrl;

    localparam int N = 10;
    localparam int H = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a_in = '0;
    logic [N-1:0]   b_in = '0;
    logic [H-1:0]   mul_op_a;
    logic [H-1:0]   mul_op_b;
    logic [2*H-2:0] mul_res;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-2:0] c_out;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [2*H-2:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [2*H-2:0] r;
        r = '0;
        for (int i = 0; i < H; i++)
            if (y[i]) r = r ^ ((2*H-1)'(x) << i);
        return r;
    endfunction

    function automatic logic [2*N-2:0] clmul_n(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-2:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (y[i]) r = r ^ ((2*N-1)'(x) << i);
        return r;
    endfunction

    // Shared external multiplier the controller drives.
    assign mul_res = clmul_h(mul_op_a, mul_op_b);

    ka_seq_mul_ctrl #(.N(N), .H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mul_op_a  (mul_op_a),
        .mul_op_b  (mul_op_b),
        .mul_res   (mul_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [N-1:0] a, input logic [N-1:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("start_in_ready", 32'(in_ready), 32'd1);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    logic [2*N-2:0] expq[$];

    initial begin
        int cyc;
        int bcnt;
        int pushes;
        int pops;
        logic acc;
        logic dn;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_mul_op_a", 32'(mul_op_a), 32'd0);
        rst = 1'b0;
        tick();

        // 1: all-ones squared, cross term operands cancel
        out_ready = 1'b1;
        start(10'h3FF, 10'h3FF);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_lo_op_a", 32'(mul_op_a), 32'h1F);
        tick();
        tick();
        chk("t1_mid_op_a", 32'(mul_op_a), 32'h00);
        chk("t1_mid_op_b", 32'(mul_op_b), 32'h00);
        chk("t1_no_early_valid", 32'(out_valid), 32'd0);
        wait_done(cyc);
        chk("t1_latency_tail", 32'(cyc), 32'd1);
        chk("t1_c_out", 32'(c_out), 32'h55555);
        tick();
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_ready", 32'(in_ready), 32'd1);

        // 2: (x^5+1)^2
        start(10'h021, 10'h021);
        chk("t2_lo_op_a", 32'(mul_op_a), 32'h01);
        chk("t2_lo_op_b", 32'(mul_op_b), 32'h01);
        wait_done(cyc);
        chk("t2_latency", 32'(cyc), 32'd3);
        chk("t2_c_out", 32'(c_out), 32'h00401);
        tick();

        // 3: 1 * x^9, count busy cycles
        start(10'h001, 10'h200);
        bcnt = 0;
        while (busy && bcnt < 20) begin
            bcnt++;
            if (out_valid) chk("t3_c_out", 32'(c_out), 32'h00200);
            tick();
        end
        chk("t3_busy_cycles", 32'(bcnt), 32'd4);

        // 4: backpressure in DONE with ignored input pulses
        out_ready = 1'b0;
        start(10'h3FF, 10'h021);
        wait_done(cyc);
        chk("t4_c_out", 32'(c_out), 32'h07C1F);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            a_in = 10'(i * 37);
            b_in = 10'(i * 91 + 5);
            tick();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_c_out", 32'(c_out), 32'h07C1F);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_rel_valid", 32'(out_valid), 32'd0);
        chk("t4_rel_in_ready", 32'(in_ready), 32'd1);
        chk("t4_rel_c_out_kept", 32'(c_out), 32'h07C1F);
        tick();
        chk("t4_stays_idle", 32'(busy), 32'd0);

        // 5: reset during MUL_HI
        start(10'h3FF, 10'h3FF);
        tick();
        chk("t5_hi_op_a", 32'(mul_op_a), 32'h1F);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_c_out", 32'(c_out), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_op_a", 32'(mul_op_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_no_pulse", 32'(out_valid), 32'd0);
        start(10'h021, 10'h021);
        wait_done(cyc);
        chk("t5_after_valid", 32'(out_valid), 32'd1);
        chk("t5_after_c_out", 32'(c_out), 32'h00401);
        tick();

        // 6: streaming random operands with random sink stalls
        pushes = 0;
        pops = 0;
        a_in = 10'($urandom);
        b_in = 10'($urandom);
        in_valid = 1'b1;
        for (int c = 0; c < 30000 && !(pushes == 1000 && expq.size() == 0); c++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            dn  = out_valid && out_ready;
            if (dn) begin
                if (expq.size() == 0) begin
                    chk("t6_spurious_out", 32'd1, 32'd0);
                end else begin
                    chk("t6_c_out", 32'(c_out), 32'(expq.pop_front()));
                    pops++;
                end
            end
            if (acc) begin
                expq.push_back(clmul_n(a_in, b_in));
                pushes++;
            end
            tick();
            if (acc) begin
                if (pushes < 1000) begin
                    a_in = 10'($urandom);
                    b_in = 10'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("t6_accepted", 32'(pushes), 32'd1000);
        chk("t6_delivered", 32'(pops), 32'd1000);
        chk("t6_leftover", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
